spu_mald_mq: RTL

SPU_MALD_MQ -- requirements
Module: spu_mald_mq

---
 rtl/spu_mald_mq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spu_mald_mq.sv
// spu_mald_mq -- MA load sequencer.
// Issues L2 line requests for a load of mactl_len 8-byte words, keeps up to
// OUTST requests in flight, and writes WPL words into MA memory for each
// returned line. The last line writes only the words still owed. An
// uncorrectable error or a forced abort stops the writes, pulses rstln, and
// drains the outstanding returns before completion.
//
// Ports
//   rclk, arst_l                 clock, async active-low reset
//   spu_mactl_iss_pulse_dly      op issue pulse (start when IDLE and ldop)
//   mactl_ldop                   current op is a load
//   mactl_len[LEN_W-1:0]         word count, sampled on start
//   ldreq_ack                    L2 accepted spu_mald_ldreq
//   ln_received                  one line returned (in request order)
//   spu_wen_ma_unc_err_pulse     uncorrectable error on a returned line
//   spu_mactl_stxa_force_abort   software abort (taken on a memwen cycle)
//   spu_mald_ldreq               L2 request, held until acked
//   spu_mald_mpa_addrinc         pulse per accepted request
//   spu_mald_memwen              MA memory write strobe, one per word
//   spu_mald_maaddr_addrinc      same as memwen
//   spu_mald_rstln               line-buffer reset on abort
//   spu_mald_done                one-cycle completion pulse
//   spu_mald_done_set            sticky load-complete flag
//   spu_mald_busy                not IDLE
module spu_mald_mq #(
  parameter int LEN_W = 6,
  parameter int OUTST = 2,
  parameter int WPL   = 2
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             spu_mactl_iss_pulse_dly,
  input  logic             mactl_ldop,
  input  logic [LEN_W-1:0] mactl_len,
  input  logic             ldreq_ack,
  input  logic             ln_received,
  input  logic             spu_wen_ma_unc_err_pulse,
  input  logic             spu_mactl_stxa_force_abort,
  output logic             spu_mald_ldreq,
  output logic             spu_mald_mpa_addrinc,
  output logic             spu_mald_memwen,
  output logic             spu_mald_maaddr_addrinc,
  output logic             spu_mald_rstln,
  output logic             spu_mald_done,
  output logic             spu_mald_done_set,
  output logic             spu_mald_busy
);

  localparam int OW  = $clog2(OUTST + 1);
  localparam int WB  = $clog2(WPL + 1);
  localparam int WSH = $clog2(WPL);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_FIN   = 4'b1000
  } state_e;

  state_e           st_q, st_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic [LEN_W-1:0] req_left_q, req_left_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [OW-1:0]    pend_q, pend_d;
  logic [WB-1:0]    wr_beats_q, wr_beats_d;
  logic             done_set_q, done_set_d;

  logic             st_idle, st_run, st_drain, st_fin;
  logic             start, ldreq, req_acc, ln_acc, memwen, abort, load;
  logic [LEN_W:0]   req_sum;
  logic [LEN_W-1:0] req_init;

  assign st_idle  = (st_q == ST_IDLE);
  assign st_run   = (st_q == ST_RUN);
  assign st_drain = (st_q == ST_DRAIN);
  assign st_fin   = (st_q == ST_FIN);

  assign start   = st_idle & spu_mactl_iss_pulse_dly & mactl_ldop;
  assign ldreq   = st_run & (req_left_q != '0) & (outst_q < OW'(OUTST));
  assign req_acc = ldreq & ldreq_ack;
  // Returns with nothing outstanding (e.g. stale ones after reset) are dropped.
  assign ln_acc  = (st_run | st_drain) & ln_received & (outst_q != '0);
  assign memwen  = st_run & (wr_beats_q != '0);
  // Force-abort only lands on a write beat; an error lands any time in RUN.
  assign abort   = st_run & (spu_wen_ma_unc_err_pulse |
                             (memwen & spu_mactl_stxa_force_abort));
  // Load stage: one idle cycle between lines, writes follow on the next cycle.
  assign load    = st_run & (wr_beats_q == '0) & (pend_q != '0);

  // ceil(len / WPL), computed one bit wider so the round-up cannot overflow.
  assign req_sum  = {1'b0, mactl_len} + (LEN_W + 1)'(WPL - 1);
  assign req_init = LEN_W'(req_sum >> WSH);

  always_comb begin
    st_d         = st_q;
    words_left_d = words_left_q;
    req_left_d   = req_left_q;
    outst_d      = outst_q;
    pend_d       = pend_q;
    wr_beats_d   = wr_beats_q;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          st_d         = ST_RUN;
          words_left_d = mactl_len;
          req_left_d   = req_init;
          outst_d      = '0;
          pend_d       = '0;
          wr_beats_d   = '0;
        end
      end
      ST_RUN: begin
        if (req_acc) req_left_d = req_left_q - LEN_W'(1);
        if (req_acc & ~ln_acc)      outst_d = outst_q + OW'(1);
        else if (~req_acc & ln_acc) outst_d = outst_q - OW'(1);
        if (ln_acc & ~load)      pend_d = pend_q + OW'(1);
        else if (~ln_acc & load) pend_d = pend_q - OW'(1);
        if (memwen) begin
          wr_beats_d   = wr_beats_q - WB'(1);
          words_left_d = words_left_q - LEN_W'(1);
        end else if (load) begin
          // Last line may owe fewer than WPL words.
          if (int'(words_left_q) < WPL) wr_beats_d = WB'(int'(words_left_q));
          else                          wr_beats_d = WB'(WPL);
        end
        if (abort) begin
          pend_d     = '0;
          wr_beats_d = '0;
          st_d       = ST_DRAIN;
        end else if ((words_left_q == '0) && (wr_beats_q == '0) &&
                     (pend_q == '0)) begin
          st_d = ST_FIN;
        end
      end
      ST_DRAIN: begin
        if (ln_acc) outst_d = outst_q - OW'(1);
        if (outst_q == '0) st_d = ST_FIN;
      end
      ST_FIN:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase

    // Clear on any issue pulse beats a same-cycle set.
    done_set_d = done_set_q;
    if (spu_mactl_iss_pulse_dly)  done_set_d = 1'b0;
    else if (st_fin & mactl_ldop) done_set_d = 1'b1;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      st_q         <= ST_IDLE;
      words_left_q <= '0;
      req_left_q   <= '0;
      outst_q      <= '0;
      pend_q       <= '0;
      wr_beats_q   <= '0;
      done_set_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      words_left_q <= words_left_d;
      req_left_q   <= req_left_d;
      outst_q      <= outst_d;
      pend_q       <= pend_d;
      wr_beats_q   <= wr_beats_d;
      done_set_q   <= done_set_d;
    end
  end

  assign spu_mald_ldreq          = ldreq;
  assign spu_mald_mpa_addrinc    = req_acc;
  assign spu_mald_memwen         = memwen;
  assign spu_mald_maaddr_addrinc = memwen;
  assign spu_mald_rstln          = abort;
  assign spu_mald_done           = st_fin;
  assign spu_mald_done_set       = done_set_q;
  assign spu_mald_busy           = ~st_idle;

endmodule
